// File: rtl/axi_uart_buffer.sv
// axi_uart_buffer: AXI4-Lite register front end with RX/TX byte FIFOs for a UART.
// Register map (addr[3:2]): 0 RX pop, 1 TX push, 2 STAT, 3 CTRL.
// Optional feature: define UART_BUF_LOOPBACK_EN to route the TX FIFO into the RX FIFO
// while CTRL bit2 is set.
module axi_uart_buffer #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [2:0]  s_axi_arprot,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [2:0]  s_axi_awprot,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(1 << AW);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic aw_ready_q, aw_ready_nxt, ar_ready_q, ar_ready_nxt;
    logic aw_hs, ar_hs;
    logic [31:0] rdata_q, rd_mux, stat_word;
    logic overrun_q;

    logic [7:0] rx_mem [0:(1<<AW)-1];
    logic [7:0] tx_mem [0:(1<<AW)-1];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush;
    logic rx_in, overrun_set, stat_rd, ctrl_wr, lb_active, lb_push;
    logic [7:0] rx_in_data, tx_head;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_araddr[31:4], s_axi_araddr[1:0], s_axi_arprot,
                             s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_awprot,
                             s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    assign aw_hs = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
    assign ar_hs = ar_ready_q & s_axi_arvalid;

    // Write FSM next state: accept AW and W together, then hold the response until taken.
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt  = w_state;
        aw_ready_nxt = 1'b0;
        case (w_state)
            W_IDLE: if (aw_hs) w_state_nxt = W_RESP;
                    else       aw_ready_nxt = s_axi_awvalid & s_axi_wvalid;
            W_RESP: if (s_axi_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state: arready is registered so no AXI input reaches an AXI output combinationally.
    always_comb begin
        r_state_nxt  = r_state;
        ar_ready_nxt = 1'b0;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
                    else       ar_ready_nxt = 1'b1;
            R_DATA: if (s_axi_rready) begin
                        r_state_nxt  = R_IDLE;
                        ar_ready_nxt = 1'b1;
                    end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // FSM state and handshake-ready registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
        end else begin
            w_state    <= w_state_nxt;
            r_state    <= r_state_nxt;
            aw_ready_q <= aw_ready_nxt;
            ar_ready_q <= ar_ready_nxt;
        end
    end

    // Register decode and FIFO control strobes.
    assign ctrl_wr  = aw_hs & (s_axi_awaddr[3:2] == 2'd3) & s_axi_wstrb[0];
    assign tx_flush = ctrl_wr & s_axi_wdata[0];
    assign rx_flush = ctrl_wr & s_axi_wdata[1];
    assign tx_push  = aw_hs & (s_axi_awaddr[3:2] == 2'd1) & s_axi_wstrb[0] & ~tx_full;
    assign stat_rd  = ar_hs & (s_axi_araddr[3:2] == 2'd2);
    assign rx_pop   = ar_hs & (s_axi_araddr[3:2] == 2'd0) & ~rx_empty;

`ifdef UART_BUF_LOOPBACK_EN
    logic lb_q;
    // Loopback enable, written through CTRL bit2.
    always_ff @(posedge clk) begin
        if (rst)          lb_q <= 1'b0;
        else if (ctrl_wr) lb_q <= s_axi_wdata[2];
    end
    assign lb_active = lb_q;
`else
    assign lb_active = 1'b0;
`endif

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_head  = tx_mem[tx_rp];

    // In loopback the TX head replaces the UART receiver as the RX source.
    assign lb_push     = lb_active & ~tx_empty & ~rx_full;
    assign rx_in       = lb_active ? lb_push : rx_valid;
    assign rx_in_data  = lb_active ? tx_head : rx_data;
    assign rx_push     = rx_in & (~rx_full | rx_pop) & ~rx_flush;
    assign overrun_set = rx_in & rx_full & ~rx_pop & ~rx_flush;
    assign tx_pop      = lb_active ? lb_push : (tx_valid & tx_ready);

    assign tx_valid = ~tx_empty & ~lb_active;
    assign tx_data  = tx_head;

    // FIFO storage writes.
    // NOTE: the byte arrays are not reset; the counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_in_data;
        if (tx_push) tx_mem[tx_wp] <= s_axi_wdata[7:0];
    end

    // RX FIFO pointers and count; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || rx_flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // TX FIFO pointers and count; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || tx_flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Sticky RX overrun: flush clears, a new overrun beats a STAT-read clear.
    always_ff @(posedge clk) begin
        if (rst || rx_flush) overrun_q <= 1'b0;
        else if (overrun_set) overrun_q <= 1'b1;
        else if (stat_rd)     overrun_q <= 1'b0;
    end

    assign stat_word = {25'b0, lb_active, overrun_q, 1'b0, tx_full, tx_empty, rx_full, ~rx_empty};

    // Read data selection at the AR handshake.
    always_comb begin
        rd_mux = 32'b0;
        case (s_axi_araddr[3:2])
            2'd0:    if (!rx_empty) rd_mux = {24'b0, rx_mem[rx_rp]};
            2'd2:    rd_mux = stat_word;
            default: rd_mux = 32'b0;
        endcase
    end

    // Read data register, held stable through R_DATA.
    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= 32'b0;
        else if (ar_hs) rdata_q <= rd_mux;
    end

    assign s_axi_arready = ar_ready_q;
    assign s_axi_awready = aw_ready_q;
    assign s_axi_wready  = aw_ready_q;
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_bresp   = 2'b00;
endmodule

// File: tb/tb_axi_uart_buffer.sv
// Self-checking bench for axi_uart_buffer: register vector table, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_axi_uart_buffer;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
    logic [2:0]  s_axi_arprot, s_axi_awprot;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_rresp, s_axi_bresp;
    logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
    logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic s_axi_bvalid, s_axi_bready;
    logic [7:0] rx_data, tx_data;
    logic rx_valid, tx_valid, tx_ready;

    int checks = 0;
    int failures = 0;

    logic [7:0] mrx[$];
    logic [7:0] mtx[$];
    bit movr = 1'b0;

    axi_uart_buffer #(.FIFO_DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_arprot(s_axi_arprot),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awprot(s_axi_awprot),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        logic [31:0] s;
        s    = 32'b0;
        s[0] = (mrx.size() != 0);
        s[1] = (mrx.size() == DEPTH);
        s[2] = (mtx.size() == 0);
        s[3] = (mtx.size() == DEPTH);
        s[5] = movr;
        return s;
    endfunction

    function automatic logic [31:0] mk_addr(input int sel);
        logic [31:0] a;
        a = $urandom();
        a[3:2] = sel[1:0];
        return a;
    endfunction

    // Entered and left at 1 time unit after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) begin
            check("aw_timeout", 32'd0, 32'd1);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check("wready_with_awready", s_axi_wready, 1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("bvalid_latency", s_axi_bvalid, 1);
        check("bresp", s_axi_bresp, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            s_axi_arvalid = 1'b0;
            data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        check("rvalid_latency", s_axi_rvalid, 1);
        check("rresp", s_axi_rresp, 0);
        data = s_axi_rdata;
    endtask

    task automatic rx_push_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic drain_one();
        @(negedge clk);
        check("tx_valid_model", tx_valid, (mtx.size() != 0));
        if (mtx.size() != 0) begin
            check("tx_data_model", tx_data, mtx[0]);
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
            void'(mtx.pop_front());
        end else begin
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        logic [7:0]  pat[17];
        int cnt;

        vecs[0]  = '{0, 32'h8,  32'h0,  4'h0, 32'h4};   // STAT after reset
        vecs[1]  = '{0, 32'h0,  32'h0,  4'h0, 32'h0};   // RX empty reads 0
        vecs[2]  = '{1, 32'h4,  32'h41, 4'h1, 32'h0};   // TX push 0x41
        vecs[3]  = '{0, 32'h8,  32'h0,  4'h0, 32'h0};   // TX no longer empty
        vecs[4]  = '{0, 32'h4,  32'h0,  4'h0, 32'h0};   // TX reads 0
        vecs[5]  = '{0, 32'hC,  32'h0,  4'h0, 32'h0};   // CTRL reads 0
        vecs[6]  = '{1, 32'h4,  32'h99, 4'hE, 32'h0};   // wstrb[0]=0: no push
        vecs[7]  = '{1, 32'h0,  32'h12, 4'hF, 32'h0};   // write RX ignored
        vecs[8]  = '{1, 32'h8,  32'hFF, 4'hF, 32'h0};   // write STAT ignored
        vecs[9]  = '{0, 32'h18, 32'h0,  4'h0, 32'h0};   // STAT alias via addr[3:2]
        vecs[10] = '{1, 32'hC,  32'h1,  4'h0, 32'h0};   // CTRL without wstrb[0]
        vecs[11] = '{0, 32'h8,  32'h0,  4'h0, 32'h0};   // TX still holds the byte

        s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_arprot = 0; s_axi_rready = 1;
        s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_awprot = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0; s_axi_bready = 1;
        rx_data = 0; rx_valid = 0; tx_ready = 0;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arready", s_axi_arready, 0);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_tx_valid", tx_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else begin
                axi_read(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end

        // TX: the single pushed byte is presented and drains
        check("tx_valid_041", tx_valid, 1);
        check("tx_data_041", tx_data, 32'h41);
        tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
        check("tx_valid_drained", tx_valid, 0);
        axi_read(32'h8, d); check("stat_after_drain", d, 32'h4);

        // RX: two bytes, visible the cycle after the push
        rx_push_byte(8'h55);
        rx_push_byte(8'hAA);
        axi_read(32'h0, d); check("rx_first", d, 32'h55);
        axi_read(32'h0, d); check("rx_second", d, 32'hAA);
        axi_read(32'h0, d); check("rx_empty_read", d, 32'h0);
        axi_read(32'h8, d); check("stat_rx_empty", d, 32'h4);

        // RX overrun: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) begin
            pat[i] = 8'(i * 7 + 3);
            rx_push_byte(pat[i]);
        end
        axi_read(32'h8, d); check("stat_overrun", d, 32'h27);
        axi_read(32'h8, d); check("stat_overrun_cleared", d, 32'h07);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h0, d); check($sformatf("ovr_byte%0d", i), d, {24'b0, pat[i]});
        end
        axi_read(32'h0, d); check("ovr_after_empty", d, 32'h0);

        // RX full with push and pop in the same cycle: no overrun, count unchanged
        for (int i = 0; i < 16; i++) rx_push_byte(pat[i]);
        s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!s_axi_arready && cnt < 20);
        check("pp_arready", s_axi_arready, 1);
        rx_data = 8'hEE; rx_valid = 1'b1;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; rx_valid = 1'b0;
        check("pp_rvalid", s_axi_rvalid, 1);
        check("pp_rdata", s_axi_rdata, {24'b0, pat[0]});
        axi_read(32'h8, d); check("pp_stat_full", d, 32'h07);
        for (int i = 1; i < 16; i++) begin
            axi_read(32'h0, d); check($sformatf("pp_byte%0d", i), d, {24'b0, pat[i]});
        end
        axi_read(32'h0, d); check("pp_last", d, 32'hEE);
        axi_read(32'h8, d); check("pp_stat_empty", d, 32'h4);

        // TX full: 17th write dropped, still OKAY
        for (int i = 0; i < 17; i++) axi_write(32'h4, {24'b0, pat[i] ^ 8'h5A}, 4'h1);
        axi_read(32'h8, d); check("stat_tx_full", d, 32'h08);
        tx_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                if (cnt < 16) check($sformatf("txfull_byte%0d", cnt), tx_data, pat[cnt] ^ 8'h5A);
                cnt++;
            end
        end
        tx_ready = 1'b0;
        @(posedge clk); #1;
        check("txfull_count", cnt, 16);
        check("txfull_empty", tx_valid, 0);

`ifdef UART_BUF_LOOPBACK_EN
        axi_write(32'hC, 32'h4, 4'h1);
        axi_write(32'h4, 32'h33, 4'h1);
        check("lb_tx_valid_forced", tx_valid, 0);
        @(posedge clk); #1;
        check("lb_tx_valid_still0", tx_valid, 0);
        axi_read(32'h0, d); check("lb_rx_byte", d, 32'h33);
        rx_push_byte(8'h77);
        axi_read(32'h8, d); check("lb_stat", d, 32'h44);
        axi_write(32'hC, 32'h0, 4'h1);
        axi_read(32'h8, d); check("lb_off_stat", d, 32'h4);
`else
        axi_write(32'hC, 32'h4, 4'h1);
        axi_read(32'h8, d); check("nolb_stat", d, 32'h4);
        axi_write(32'h4, 32'h33, 4'h1);
        check("nolb_tx_valid", tx_valid, 1);
        check("nolb_tx_data", tx_data, 32'h33);
        tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
        axi_write(32'hC, 32'h0, 4'h1);
`endif

        // Random traffic against the queue model (both FIFOs empty, no overrun)
        mrx.delete(); mtx.delete(); movr = 1'b0;
        for (int it = 0; it < 400; it++) begin
            int op, sel, r;
            logic [31:0] data, exp;
            logic [3:0]  strb;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: begin
                    data = $urandom();
                    rx_push_byte(data[7:0]);
                    if (mrx.size() < DEPTH) mrx.push_back(data[7:0]);
                    else movr = 1'b1;
                end
                3, 4, 9: begin
                    r = $urandom_range(0, 9);
                    sel = (r < 7) ? 1 : (r == 7) ? 0 : (r == 8) ? 2 : 3;
                    strb = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) strb[0] = 1'b1;
                    data = $urandom();
                    if (sel == 3) data[2] = 1'b0;
                    axi_write(mk_addr(sel), data, strb);
                    if (strb[0]) begin
                        if (sel == 1 && mtx.size() < DEPTH) mtx.push_back(data[7:0]);
                        if (sel == 3) begin
                            if (data[0]) mtx.delete();
                            if (data[1]) begin mrx.delete(); movr = 1'b0; end
                        end
                    end
                end
                5, 6, 7: begin
                    sel = (op == 5) ? 0 : (op == 7) ? 2 : $urandom_range(0, 3);
                    exp = 32'h0;
                    if (sel == 0 && mrx.size() != 0) exp = {24'b0, mrx.pop_front()};
                    if (sel == 2) begin exp = m_stat(); movr = 1'b0; end
                    axi_read(mk_addr(sel), d);
                    check($sformatf("rand%0d_sel%0d", it, sel), d, exp);
                end
                default: drain_one();
            endcase
        end
        axi_read(32'h8, d); check("rand_final_stat", d, m_stat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_uart_buffer.md
# axi_uart_buffer

AXI4-Lite responder that terminates the core's `uart_axi_*` initiator port and buffers bytes between the core and the UART serializer/deserializer. It holds a receive FIFO, filled by the UART receiver, and a transmit FIFO, drained by the UART transmitter. It exposes a four-register map (RX, TX, STAT, CTRL) at word offsets 0x0–0xC. The block sits between the core's UART bus and the physical UART rx/tx modules, in the `clk` domain.

## Interface
- `FIFO_DEPTH_LOG2`, 4 — log2 of each FIFO depth (default 16 entries per FIFO).
- `clk` in 1 — sole clock; every register updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `s_axi_araddr` in 32; `s_axi_arvalid` in 1; `s_axi_arready` out 1; `s_axi_arprot` in 3 (ignored) — read address channel.
- `s_axi_rdata` out 32; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1 — read data channel.
- `s_axi_awaddr` in 32; `s_axi_awvalid` in 1; `s_axi_awready` out 1; `s_axi_awprot` in 3 (ignored) — write address channel.
- `s_axi_wdata` in 32; `s_axi_wstrb` in 4; `s_axi_wvalid` in 1; `s_axi_wready` out 1 — write data channel.
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1 — write response channel.
- `rx_data` in 8; `rx_valid` in 1 — one-cycle byte strobe from the UART receiver. There is no backpressure on this input.
- `tx_data` out 8; `tx_valid` out 1; `tx_ready` in 1 — byte stream to the UART transmitter. A byte transfers when `tx_valid & tx_ready`.

## Operation
- **Address decode:** uses `addr[3:2]` only; all other address bits are ignored. `resp` is always OKAY (2'b00).
- **0x0 RX (read):**
  - If the RX FIFO is non-empty: returns {24'b0, head byte} and pops the FIFO at the AR handshake.
  - If the RX FIFO is empty: returns 0 and does not pop.
  - Writes to 0x0 are ignored.
- **0x4 TX (write):**
  - If `wstrb[0]` is set and the TX FIFO is not full: pushes `wdata[7:0]`.
  - If the TX FIFO is full: the write is silently dropped.
  - Reads of 0x4 return 0.
- **0x8 STAT (read):** bit0 = RX non-empty, bit1 = RX full, bit2 = TX empty, bit3 = TX full, bit5 = RX overrun, bit6 = loopback active; all other bits are 0.
  - A read of STAT clears the overrun bit. If a new overrun occurs in the same cycle, set wins.
  - Writes to 0x8 are ignored.
- **0xC CTRL (write, `wstrb[0]` required):**
  - bit0 = flush TX FIFO (self-clearing).
  - bit1 = flush RX FIFO (self-clearing); also clears overrun.
  - bit2 = loopback enable (persistent; see Configuration).
  - Reads of 0xC return 0.
- **RX push:**
  - `rx_valid` while the RX FIFO is not full: the byte is pushed.
  - `rx_valid` while full, with a pop in the same cycle: the byte is pushed and the count is unchanged.
  - `rx_valid` while full, with no pop: the byte is dropped and overrun is set.
- **FIFO occupancy:** each FIFO keeps a count of width `FIFO_DEPTH_LOG2+1` and pointers of width `FIFO_DEPTH_LOG2`; pointers wrap modulo depth.
  - Simultaneous push and pop leaves the count unchanged.
  - A flush takes priority over a push or pop in the same cycle.
- **TX output:** `tx_valid` = TX FIFO non-empty; `tx_data` = head byte (combinational from storage). The pop occurs on `tx_valid & tx_ready`.
- **Write FSM:** W_IDLE → W_RESP → W_IDLE.
  - In W_IDLE: `awready` and `wready` are asserted together for one cycle, only when both `awvalid` and `wvalid` are high. The register effect takes place in that cycle. Next state is W_RESP.
  - In W_RESP: `bvalid` is held high until `bready`, then return to W_IDLE.
- **Read FSM:** R_IDLE → R_DATA → R_IDLE.
  - In R_IDLE: `arready` = 1. On `arvalid`, the read data is latched into the `rdata` register and any pop/clear side effect is performed. Next state is R_DATA.
  - In R_DATA: `rvalid` is held high and `rdata` is stable until `rready`.
- **Read/write independence:** the read and write FSMs run independently. An RX read and a TX write may complete in the same cycle.

## Timing
- **Reset values (applied in the cycle after `rst` is sampled high):**
  - `arready` = `awready` = `wready` = `bvalid` = `rvalid` = 0.
  - `rdata` = 0, `rresp` = `bresp` = 0.
  - Both FIFOs empty, so `tx_valid` = 0.
  - Overrun = 0, loopback = 0.
  - Both FSMs in IDLE.
- **Reset mid-transaction:** reset abandons any outstanding transaction; no response is issued afterwards.
- **Read latency:** AR handshake in cycle N → `rvalid` high in N+1. With `rready` tied high, throughput is one read every 2 cycles.
- **Write latency:** AW/W handshake in cycle N → `bvalid` high in N+1. The pushed byte is visible on `tx_valid` in N+1.
- **RX visibility:** a byte pushed in cycle N is visible in STAT bit0 and readable from an AR handshake in cycle N+1 onward.
- **No combinational paths:** there is no combinational path from any AXI input to any AXI output.

## Configuration
- **`UART_BUF_LOOPBACK_EN` defined:**
  - When CTRL bit2 is set: the TX FIFO head feeds the RX FIFO push, one byte per cycle, whenever the RX FIFO is not full.
  - `tx_valid` is forced to 0 and `rx_valid` is ignored.
  - STAT bit6 reflects the loopback state.
- **`UART_BUF_LOOPBACK_EN` undefined:** CTRL bit2 is ignored and STAT bit6 reads 0.

## Test plan
- **Reset:** hold `rst` for 2 cycles → all AXI valid/ready outputs are 0; STAT read then returns 0x4.
- **TX write:** write 0x41 to 0x4 → `bvalid` 1 cycle after the handshake; `tx_valid`=1 with `tx_data`=0x41; after `tx_ready` the STAT read returns 0x4.
- **RX read:** pulse `rx_valid` with bytes 0x55, 0xAA → successive RX reads return 0x55, 0xAA, then 0x0; STAT bit0 reads 0 after the second read.
- **RX overrun:**
  - Action: push 17 bytes into a 16-deep RX FIFO.
  - Expected: STAT reads 0x27, i.e. RX non-empty, RX full, TX empty and overrun set.
  - Expected: a second STAT read returns 0x7.
  - Expected: the 16 bytes read back are the first 16 pushed.
- **TX full:** fill the TX FIFO with `tx_ready`=0, then write a 17th byte → OKAY response, byte dropped, STAT bit3=1; draining yields exactly 16 bytes.
- **Loopback (macro defined):**
  - Action: write CTRL=0x4, then write 0x33 to TX.
  - Expected: `tx_valid` stays 0.
  - Expected: an RX read within 3 cycles of `bvalid` returns 0x33.
